// File: rtl/tx_frame_gen_if.sv
// Upstream payload stream into tx_frame_gen.
// Valid/ready: the source holds s_data and s_last stable while s_valid=1 and
// s_ready=0; a word transfers on a clk edge where s_valid=1 and s_ready=1.
interface tx_frame_gen_if;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_last;
  logic        s_ready;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/tx_frame_gen.sv
// Frames 16-bit payload words into a byte stream for an 8b10b encoder:
// commas between frames, SOF/EOF K-codes, in-frame filler and a byte checksum.
module tx_frame_gen #(
  parameter int unsigned IDLE_GAP = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tx_en_i,
  tx_frame_gen_if.slave s,
  output logic          enc_ein_o,
  output logic          enc_kin_o,
  output logic [7:0]    enc_dat_o,
  output logic [15:0]   frame_cnt_o,
  output logic [2:0]    state_o
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SOF     = 3'd1,
    ST_DATA_LO = 3'd2,
    ST_DATA_HI = 3'd3,
    ST_STALL   = 3'd4,
    ST_CSUM    = 3'd5,
    ST_EOF     = 3'd6
  } state_e;

  localparam logic [7:0] K_COMMA = 8'hBC;  // K28.5
  localparam logic [7:0] K_SOF   = 8'hFB;  // K27.7
  localparam logic [7:0] K_STALL = 8'hF7;  // K23.7
  localparam logic [7:0] K_EOF   = 8'hFD;  // K29.7

  state_e      state_q, state_d;
  logic [7:0]  gap_q, gap_d;
  logic [15:0] hold_q, hold_d;
  logic        hold_last_q, hold_last_d;
  logic [7:0]  sum_q, sum_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        ein_q, ein_d;
  logic        kin_q, kin_d;
  logic [7:0]  dat_q, dat_d;
  logic        ready;
  logic        load_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gap_q       <= 8'(IDLE_GAP);
      hold_q      <= '0;
      hold_last_q <= 1'b0;
      sum_q       <= '0;
      frame_cnt_q <= '0;
      ein_q       <= 1'b0;
      kin_q       <= 1'b0;
      dat_q       <= '0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      hold_q      <= hold_d;
      hold_last_q <= hold_last_d;
      sum_q       <= sum_d;
      frame_cnt_q <= frame_cnt_d;
      ein_q       <= ein_d;
      kin_q       <= kin_d;
      dat_q       <= dat_d;
    end
  end

  // Sum accumulates on the edge that enters the state emitting each byte,
  // so by DATA_HI of the last word it already covers every payload byte.
  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    sum_d       = sum_q;
    frame_cnt_d = frame_cnt_q;
    ready       = 1'b0;
    load_word   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (gap_q != 8'd0) begin
          gap_d = gap_q - 8'd1;
        end else if (tx_en_i && s.s_valid) begin
          state_d = ST_SOF;
        end
      end
      ST_SOF: begin
        ready     = 1'b1;
        load_word = 1'b1;
        sum_d     = s.s_data[7:0];
        state_d   = ST_DATA_LO;
      end
      ST_DATA_LO: begin
        sum_d   = sum_q + hold_q[15:8];
        state_d = ST_DATA_HI;
      end
      ST_DATA_HI: begin
        if (hold_last_q) begin
          state_d = ST_CSUM;
        end else begin
          ready = 1'b1;
          if (s.s_valid) begin
            load_word = 1'b1;
            sum_d     = sum_q + s.s_data[7:0];
            state_d   = ST_DATA_LO;
          end else begin
            state_d = ST_STALL;
          end
        end
      end
      ST_STALL: begin
        ready = 1'b1;
        if (s.s_valid) begin
          load_word = 1'b1;
          sum_d     = sum_q + s.s_data[7:0];
          state_d   = ST_DATA_LO;
        end
      end
      ST_CSUM: begin
        state_d = ST_EOF;
      end
      ST_EOF: begin
        frame_cnt_d = frame_cnt_q + 16'd1;
        gap_d       = 8'(IDLE_GAP - 1);
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    hold_d      = hold_q;
    hold_last_d = hold_last_q;
    if (load_word) begin
      hold_d      = s.s_data;
      hold_last_d = s.s_last;
    end
  end

  // Encoder byte reflects the state being entered on this edge.
  always_comb begin
    ein_d = 1'b0;
    kin_d = 1'b1;
    dat_d = K_COMMA;
    unique case (state_d)
      ST_IDLE:    dat_d = K_COMMA;
      ST_SOF:     dat_d = K_SOF;
      ST_DATA_LO: begin ein_d = 1'b1; kin_d = 1'b0; dat_d = hold_d[7:0];  end
      ST_DATA_HI: begin ein_d = 1'b1; kin_d = 1'b0; dat_d = hold_d[15:8]; end
      ST_STALL:   dat_d = K_STALL;
      ST_CSUM:    begin ein_d = 1'b1; kin_d = 1'b0; dat_d = sum_d;        end
      ST_EOF:     dat_d = K_EOF;
      default:    dat_d = K_COMMA;
    endcase
  end

  assign s.s_ready   = ready;
  assign enc_ein_o   = ein_q;
  assign enc_kin_o   = kin_q;
  assign enc_dat_o   = dat_q;
  assign frame_cnt_o = frame_cnt_q;
  assign state_o     = state_q;

endmodule

// File: doc/tx_frame_gen.md
TX_FRAME_GEN -- requirements
Module: tx_frame_gen

Interface
REQ-001 Parameter IDLE_GAP, default 4, range 1..255: minimum number of K28.5 comma bytes emitted between consecutive frames.
REQ-002 clk  in  1  clock; reset rst, asynchronous, active-high.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 tx_en  in  1  frame start permitted; sampled only in IDLE.
REQ-005 s_valid  in  1  upstream word valid; s_data and s_last are held stable while s_valid=1 and s_ready=0.
REQ-006 s_data  in  16  payload word; low byte is transmitted first.
REQ-007 s_last  in  1  marks the final word of a frame.
REQ-008 s_ready  out  1  combinational; a word is accepted on a clock edge where s_valid=1 and s_ready=1.
REQ-009 enc_ein  out  1  registered; data byte strobe to the 8b10b encoder.
REQ-010 enc_kin  out  1  registered; K-code strobe to the 8b10b encoder.
REQ-011 enc_dat  out  8  registered byte to the encoder.
REQ-012 frame_cnt  out  16  registered count of completed frames; wraps 0xFFFF->0x0000.

Function
REQ-013 After reset, exactly one of enc_ein/enc_kin shall be 1 in every cycle, giving the encoder one byte per clk.
REQ-014 States: IDLE, SOF, DATA_LO, DATA_HI, STALL, CSUM, EOF; the enc_* registers are loaded on the same edge that enters a state and show that state's byte.
REQ-015 IDLE: emit K28.5 (0xBC, kin=1); decrement gap_cnt while nonzero; go to SOF when gap_cnt=0, tx_en=1 and s_valid=1; otherwise stay in IDLE.
REQ-016 SOF: emit K27.7 (0xFB, kin); s_ready=1; accept word into hold register (s_valid guaranteed); clear sum to 0; go to DATA_LO.
REQ-017 DATA_LO: emit hold[7:0] (ein); s_ready=0; go to DATA_HI.
REQ-018 DATA_HI: emit hold[15:8] (ein); if hold_last=1 then s_ready=0 and go to CSUM; else s_ready=1, and on accept go to DATA_LO, otherwise go to STALL.
REQ-019 STALL: emit K23.7 (0xF7, kin) as the in-frame filler; s_ready=1; on accept go to DATA_LO, else stay in STALL (no timeout).
REQ-020 Checksum: sum = 8-bit modulo-256 sum of every payload byte of the frame, overflow discarded; CSUM emits sum (ein); go to EOF.
REQ-021 EOF: emit K29.7 (0xFD, kin); frame_cnt+1; gap_cnt loads IDLE_GAP-1; go to IDLE.
REQ-022 The sum shall include both bytes of the last word, and the CSUM byte shall reflect them.
REQ-023 s_ready shall be 0 in IDLE, DATA_LO, CSUM and EOF.
REQ-024 tx_en deassertion mid-frame shall not affect the frame; it gates only the IDLE->SOF decision.
REQ-025 A single-word frame produces the sequence SOF, LO, HI, CSUM, EOF; the minimum frame is 5 bytes.
REQ-026 Back-to-back frames shall be separated by exactly IDLE_GAP commas when s_valid stays high.

Reset
REQ-027 On rst: state=IDLE, gap_cnt=IDLE_GAP, enc_ein=0, enc_kin=0, enc_dat=0x00, frame_cnt=0, sum=0, hold=0, s_ready=0.
REQ-028 On the first edge after rst release: enc_kin=1, enc_dat=0xBC.
REQ-029 rst asserted mid-frame shall abort immediately, with no EOF or CSUM emitted and frame_cnt unchanged from reset (0).

Verification
REQ-030 Idle: rst release, s_valid=0 -> continuous kin=1/0xBC, s_ready never 1.
REQ-031 One word 0x1234, last=1, IDLE_GAP=4 -> 4 commas, then FB(k), 34, 12, 46, FD(k), then BC; frame_cnt=1.
REQ-032 Stall: words 0x00FF then (2 cycles late) 0xFF01 last -> FB, FF, 00, F7, F7, 01, FF, FF(sum 0x1FF mod 256), FD.
REQ-033 Back-to-back frames with s_valid held -> exactly IDLE_GAP 0xBC between FD and next FB; no word dropped or duplicated, verified against a scoreboard.
REQ-034 Reset mid-DATA_HI -> outputs 0 during rst, then 0xBC; frame_cnt=0; the next frame is well formed.
REQ-035 frame_cnt preloaded via 65535 frames (or forced) -> wraps to 0x0000; tx_en=0 with s_valid=1 -> IDLE held, s_ready=0.
